// File: rtl/corr_pkg.sv
// Shared types and constants for the correlation peak search block.
package corr_pkg;

    localparam int unsigned COORD_W = 13;
    localparam int unsigned SCORE_W = 32;

    // Off-window coordinate used to force both scorer inputs to change.
    localparam logic [COORD_W-1:0] PARK_COORD = 13'h1FFF;

    typedef enum logic [2:0] {
        StIdle,
        StPark,
        StLaunch,
        StSettle,
        StWait,
        StLatch,
        StCompare,
        StDone
    } state_e;

endpackage

// File: rtl/corr_best_tracker.sv
// Best-candidate tracker: keeps the first or strictly higher score seen in a scan.
module corr_best_tracker
    import corr_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic               cmp_en_i,
    input  logic [COORD_W-1:0] x_i,
    input  logic [COORD_W-1:0] y_i,
    input  logic [SCORE_W-1:0] score_i,
    output logic [COORD_W-1:0] best_x_o,
    output logic [COORD_W-1:0] best_y_o,
    output logic [SCORE_W-1:0] best_score_o
);

    logic               first_q, first_d;
    logic [COORD_W-1:0] best_x_q, best_x_d;
    logic [COORD_W-1:0] best_y_q, best_y_d;
    logic [SCORE_W-1:0] best_score_q, best_score_d;

    // Next-state: the first compare of a scan always wins, later ones need a strictly greater score.
    always_comb begin
        first_d      = first_q;
        best_x_d     = best_x_q;
        best_y_d     = best_y_q;
        best_score_d = best_score_q;
        if (start_i) begin
            first_d = 1'b1;
        end else if (cmp_en_i) begin
            if (first_q || (score_i > best_score_q)) begin
                best_x_d     = x_i;
                best_y_d     = y_i;
                best_score_d = score_i;
            end
            first_d = 1'b0;
        end
    end

    // Best-so-far registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            first_q      <= 1'b0;
            best_x_q     <= '0;
            best_y_q     <= '0;
            best_score_q <= '0;
        end else begin
            first_q      <= first_d;
            best_x_q     <= best_x_d;
            best_y_q     <= best_y_d;
            best_score_q <= best_score_d;
        end
    end

    assign best_x_o     = best_x_q;
    assign best_y_o     = best_y_q;
    assign best_score_o = best_score_q;

endmodule

// File: rtl/corr_peak_search.sv
// Raster scan controller for the correlation scorer with peak picking.
module corr_peak_search
    import corr_pkg::*;
#(
    parameter int unsigned X_MIN      = 0,
    parameter int unsigned X_MAX      = 63,
    parameter int unsigned Y_MIN      = 0,
    parameter int unsigned Y_MAX      = 47,
    parameter int unsigned STEP       = 1,
    parameter int unsigned SETTLE_CYC = 2,
    parameter int unsigned SCORE_LAT  = 1,
    parameter int unsigned TIMEOUT    = 1 << 20
) (
    input  logic               iCLK,
    input  logic               iRST,
    input  logic               iStart,
    output logic [COORD_W-1:0] oXstart,
    output logic [COORD_W-1:0] oYstart,
    input  logic               iCorrFinished,
    input  logic [SCORE_W-1:0] iCorrScore,
    output logic               oBusy,
    output logic               oDone,
    output logic               oTimeout,
    output logic [COORD_W-1:0] oBestX,
    output logic [COORD_W-1:0] oBestY,
    output logic [SCORE_W-1:0] oBestScore
);

    state_e             state_q, state_d;
    logic [COORD_W-1:0] cur_x_q, cur_x_d;
    logic [COORD_W-1:0] cur_y_q, cur_y_d;
    logic [COORD_W-1:0] xs_q, xs_d;
    logic [COORD_W-1:0] ys_q, ys_d;
    logic [31:0]        cnt_q, cnt_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic               timeout_q, timeout_d;
    logic               start_scan;
    logic               cmp_en;
    // One extra bit so the +STEP carry near the top of the coordinate range cannot wrap.
    logic [COORD_W:0]   nx;
    logic [COORD_W:0]   ny;

    assign nx = {1'b0, cur_x_q} + 14'(STEP);
    assign ny = {1'b0, cur_y_q} + 14'(STEP);

    // Next-state and datapath control for the scan FSM.
    always_comb begin
        state_d    = state_q;
        cur_x_d    = cur_x_q;
        cur_y_d    = cur_y_q;
        xs_d       = xs_q;
        ys_d       = ys_q;
        cnt_d      = cnt_q;
        score_d    = score_q;
        timeout_d  = timeout_q;
        start_scan = 1'b0;
        cmp_en     = 1'b0;
        case (state_q)
            StIdle: begin
                if (iStart) begin
                    cur_x_d    = 13'(X_MIN);
                    cur_y_d    = 13'(Y_MIN);
                    timeout_d  = 1'b0;
                    start_scan = 1'b1;
                    xs_d       = PARK_COORD;
                    ys_d       = PARK_COORD;
                    state_d    = StPark;
                end
            end
            StPark: begin
                xs_d    = cur_x_q;
                ys_d    = cur_y_q;
                state_d = StLaunch;
            end
            StLaunch: begin
                cnt_d   = '0;
                state_d = (SETTLE_CYC == 0) ? StWait : StSettle;
            end
            StSettle: begin
                // The finished flag may still be high from the previous candidate here.
                if (cnt_q == 32'(SETTLE_CYC - 1)) begin
                    cnt_d   = '0;
                    state_d = StWait;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            StWait: begin
                if (iCorrFinished) begin
                    cnt_d = '0;
                    if (SCORE_LAT == 0) begin
                        score_d = iCorrScore;
                        state_d = StCompare;
                    end else begin
                        state_d = StLatch;
                    end
                end else if (cnt_q >= 32'(TIMEOUT - 1)) begin
                    timeout_d = 1'b1;
                    state_d   = StDone;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            StLatch: begin
                if (cnt_q == 32'(SCORE_LAT - 1)) begin
                    score_d = iCorrScore;
                    state_d = StCompare;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            StCompare: begin
                cmp_en = 1'b1;
                if (nx > 14'(X_MAX)) begin
                    cur_x_d = 13'(X_MIN);
                    cur_y_d = ny[COORD_W-1:0];
                    if (ny > 14'(Y_MAX)) begin
                        state_d = StDone;
                    end else begin
                        xs_d    = PARK_COORD;
                        ys_d    = PARK_COORD;
                        state_d = StPark;
                    end
                end else begin
                    cur_x_d = nx[COORD_W-1:0];
                    xs_d    = PARK_COORD;
                    ys_d    = PARK_COORD;
                    state_d = StPark;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State, coordinate, counter and score registers.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state_q   <= StIdle;
            cur_x_q   <= '0;
            cur_y_q   <= '0;
            xs_q      <= PARK_COORD;
            ys_q      <= PARK_COORD;
            cnt_q     <= '0;
            score_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cur_x_q   <= cur_x_d;
            cur_y_q   <= cur_y_d;
            xs_q      <= xs_d;
            ys_q      <= ys_d;
            cnt_q     <= cnt_d;
            score_q   <= score_d;
            timeout_q <= timeout_d;
        end
    end

    corr_best_tracker u_best (
        .clk_i       (iCLK),
        .rst_i       (iRST),
        .start_i     (start_scan),
        .cmp_en_i    (cmp_en),
        .x_i         (cur_x_q),
        .y_i         (cur_y_q),
        .score_i     (score_q),
        .best_x_o    (oBestX),
        .best_y_o    (oBestY),
        .best_score_o(oBestScore)
    );

    assign oXstart  = xs_q;
    assign oYstart  = ys_q;
    assign oBusy    = (state_q != StIdle) && (state_q != StDone);
    assign oDone    = (state_q == StDone);
    assign oTimeout = timeout_q;

endmodule

// File: tb/tb_corr_peak_search.sv
// Directed bench for corr_peak_search with a behavioural scorer model.
`timescale 1ns/1ps
module tb_corr_peak_search;

    localparam logic [12:0] PARK = 13'h1FFF;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, start2;
    logic        fin, fin2;
    logic [31:0] score, score2;
    logic [12:0] ox, oy, bx, by, ox2, oy2, bx2, by2;
    logic [31:0] bs, bs2;
    logic        busy, done, tmo, busy2, done2, tmo2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    corr_peak_search #(
        .X_MIN(0), .X_MAX(3), .Y_MIN(0), .Y_MAX(1), .STEP(1),
        .SETTLE_CYC(2), .SCORE_LAT(1), .TIMEOUT(64)
    ) dut (
        .iCLK(clk), .iRST(rst), .iStart(start), .oXstart(ox), .oYstart(oy),
        .iCorrFinished(fin), .iCorrScore(score), .oBusy(busy), .oDone(done),
        .oTimeout(tmo), .oBestX(bx), .oBestY(by), .oBestScore(bs)
    );

    corr_peak_search #(
        .X_MIN(5), .X_MAX(5), .Y_MIN(7), .Y_MAX(7), .STEP(1),
        .SETTLE_CYC(2), .SCORE_LAT(1), .TIMEOUT(64)
    ) dut2 (
        .iCLK(clk), .iRST(rst), .iStart(start2), .oXstart(ox2), .oYstart(oy2),
        .iCorrFinished(fin2), .iCorrScore(score2), .oBusy(busy2), .oDone(done2),
        .oTimeout(tmo2), .oBestX(bx2), .oBestY(by2), .oBestScore(bs2)
    );

    // Scorer model controls.
    int score_mode = 0;
    bit stale_en   = 1'b0;
    bit hang_en    = 1'b0;
    int hang_x     = 0;

    function automatic logic [31:0] score_of(input int mode, input int x, input int y);
        case (mode)
            0: return 32'(100 + x + 10 * y);
            1: return 32'd500;
            2: return 32'(200 - x - 10 * y);
            3: return (x == 1 && y == 1) ? 32'd900 : 32'(x);
            4: return 32'(x);
            5: return (x == 2 && y == 1) ? 32'hFFFF_FFF0 : 32'h7FFF_FFFF;
            default: return 32'd0;
        endcase
    endfunction

    // Scorer: restarts when both coords change to a non-park value; finished may stay stale-high.
    logic [12:0] px = PARK, py = PARK;
    bit running = 1'b0;
    int stale_cnt = 0;
    int run_cnt = 0;
    always @(negedge clk) begin
        if (ox != px && oy != py && ox != PARK && oy != PARK) begin
            running   = 1'b1;
            stale_cnt = stale_en ? 3 : 0;
            run_cnt   = 3;
            if (!stale_en) fin = 1'b0;
        end else if (running) begin
            if (stale_cnt > 0) begin
                stale_cnt--;
                if (stale_cnt == 0) fin = 1'b0;
            end else if (hang_en && ox == 13'(hang_x) && oy == 13'd0) begin
                fin = 1'b0;
            end else if (run_cnt > 0) begin
                run_cnt--;
            end else begin
                fin     = 1'b1;
                score   = score_of(score_mode, int'(ox), int'(oy));
                running = 1'b0;
            end
        end
        px = ox;
        py = oy;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Runs one scan; reports launches, done pulses, cycles from last launch to done, first coords.
    task automatic run_scan(input int busy_at, output int launches, output int dones,
                            output int tail, output logic [12:0] fx, output logic [12:0] fy);
        bit prev_park;
        bit ok;
        launches = 0;
        dones    = 0;
        tail     = 0;
        fx       = PARK;
        fy       = PARK;
        ok       = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", 32'(busy), 32'd1);
        prev_park = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if (prev_park && ox != PARK) begin
                if (launches == 0) begin
                    fx = ox;
                    fy = oy;
                end
                launches++;
                tail = 0;
            end else begin
                tail++;
            end
            prev_park = (ox == PARK);
            if (done) begin
                dones++;
                ok = 1'b1;
                check("busy_low_at_done", 32'(busy), 32'd0);
                break;
            end
            start = (i == busy_at);
            @(negedge clk);
        end
        start = 1'b0;
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL scan_budget: no oDone within 3000 cycles");
        end
        @(negedge clk);
        check("done_single_pulse", 32'(done), 32'd0);
    endtask

    typedef struct {
        int          mode;
        bit          stale;
        bit          hang;
        int          busy_at;
        logic [12:0] ex;
        logic [12:0] ey;
        logic [31:0] es;
        bit          eto;
        int          elaunch;
        int          etail;
    } vec_t;

    vec_t vecs[9];

    initial begin
        int          l, d, t;
        logic [12:0] fx, fy;
        bit          ok2;

        vecs[0] = '{0, 1'b0, 1'b0, -1, 13'd3, 13'd1, 32'd113, 1'b0, 8, 7};
        vecs[1] = '{1, 1'b0, 1'b0, -1, 13'd0, 13'd0, 32'd500, 1'b0, 8, 7};
        vecs[2] = '{0, 1'b1, 1'b0, -1, 13'd3, 13'd1, 32'd113, 1'b0, 8, 10};
        vecs[3] = '{2, 1'b0, 1'b0, -1, 13'd0, 13'd0, 32'd200, 1'b0, 8, 7};
        vecs[4] = '{3, 1'b0, 1'b0, -1, 13'd1, 13'd1, 32'd900, 1'b0, 8, 7};
        vecs[5] = '{4, 1'b0, 1'b0, -1, 13'd3, 13'd0, 32'd3, 1'b0, 8, 7};
        vecs[6] = '{5, 1'b0, 1'b0, -1, 13'd2, 13'd1, 32'hFFFF_FFF0, 1'b0, 8, 7};
        vecs[7] = '{0, 1'b0, 1'b0, 20, 13'd3, 13'd1, 32'd113, 1'b0, 8, 7};
        vecs[8] = '{0, 1'b0, 1'b1, -1, 13'd1, 13'd0, 32'd101, 1'b1, 3, 67};

        rst    = 1'b1;
        start  = 1'b0;
        start2 = 1'b0;
        fin    = 1'b0;
        fin2   = 1'b0;
        score  = '0;
        score2 = '0;
        #12;
        check("rst_x", 32'(ox), 32'(PARK));
        check("rst_y", 32'(oy), 32'(PARK));
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_timeout", 32'(tmo), 32'd0);
        check("rst_best", {6'd0, bx, by}, 32'd0);
        check("rst_best_score", bs, 32'd0);
        check("rst2_x", 32'(ox2), 32'(PARK));
        @(negedge clk);
        rst = 1'b0;

        for (int v = 0; v < 9; v++) begin
            score_mode = vecs[v].mode;
            stale_en   = vecs[v].stale;
            hang_en    = vecs[v].hang;
            hang_x     = 2;
            run_scan(vecs[v].busy_at, l, d, t, fx, fy);
            check($sformatf("v%0d_launches", v), 32'(l), 32'(vecs[v].elaunch));
            check($sformatf("v%0d_dones", v), 32'(d), 32'd1);
            check($sformatf("v%0d_tail", v), 32'(t), 32'(vecs[v].etail));
            check($sformatf("v%0d_best_x", v), 32'(bx), 32'(vecs[v].ex));
            check($sformatf("v%0d_best_y", v), 32'(by), 32'(vecs[v].ey));
            check($sformatf("v%0d_best_score", v), bs, vecs[v].es);
            check($sformatf("v%0d_timeout", v), 32'(tmo), 32'(vecs[v].eto));
        end

        // Asynchronous reset while waiting on a hung candidate.
        score_mode = 0;
        stale_en   = 1'b0;
        hang_en    = 1'b1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("tmo_cleared_on_start", 32'(tmo), 32'd0);
        ok2 = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (ox == 13'd2) begin
                ok2 = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("reach_candidate_2", 32'(ok2), 32'd1);
        repeat (6) @(negedge clk);
        check("pre_rst_busy", 32'(busy), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_x", 32'(ox), 32'(PARK));
        check("arst_y", 32'(oy), 32'(PARK));
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        check("arst_timeout", 32'(tmo), 32'd0);
        check("arst_best", {6'd0, bx, by}, 32'd0);
        check("arst_best_score", bs, 32'd0);
        @(negedge clk);
        rst     = 1'b0;
        hang_en = 1'b0;
        run_scan(-1, l, d, t, fx, fy);
        check("post_rst_first_x", 32'(fx), 32'd0);
        check("post_rst_first_y", 32'(fy), 32'd0);
        check("post_rst_launches", 32'(l), 32'd8);
        check("post_rst_best_x", 32'(bx), 32'd3);
        check("post_rst_best_y", 32'(by), 32'd1);
        check("post_rst_best_score", bs, 32'd113);

        // Single-candidate window on the second instance.
        @(negedge clk);
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        ok2 = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (ox2 != PARK) begin
                ok2 = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("w1_launch_seen", 32'(ok2), 32'd1);
        check("w1_launch_x", 32'(ox2), 32'd5);
        check("w1_launch_y", 32'(oy2), 32'd7);
        repeat (4) @(negedge clk);
        score2 = 32'd175;
        fin2   = 1'b1;
        ok2    = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (done2) begin
                ok2 = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("w1_done", 32'(ok2), 32'd1);
        check("w1_best_x", 32'(bx2), 32'd5);
        check("w1_best_y", 32'(by2), 32'd7);
        check("w1_best_score", bs2, 32'd175);
        check("w1_timeout", 32'(tmo2), 32'd0);
        @(negedge clk);
        check("w1_done_pulse", 32'(done2), 32'd0);
        check("w1_idle", 32'(busy2), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
